// File: rtl/dsp_sample_loader_if.sv
// Bus bundle between dsp_sample_loader and its environment.
// The bundle carries three groups of signals:
//   - the sample stream (valid/ready, data, last)
//   - the data-memory write port
//   - the dsp_core start/done handshake
// The slave modport is the loader's view of the bundle.
// The master modport is the view of the sample source / memory / core side.
interface dsp_sample_loader_if #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_last;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                core_start;
    logic                core_done;

    modport master (
        output s_valid, s_data, s_last, core_done,
        input  s_ready, mem_we, mem_addr, mem_wdata, core_start
    );

    modport slave (
        input  s_valid, s_data, s_last, core_done,
        output s_ready, mem_we, mem_addr, mem_wdata, core_start
    );
endinterface

// File: rtl/dsp_sample_loader.sv
// dsp_sample_loader: loads one frame of signed samples into dsp_core data memory,
// then pulses core_start and waits for core_done before accepting the next arm.
// Optional feature macro: DSP_LOADER_PAD_EN. When it is defined, a frame that ends
// early (s_last before len samples) zero-fills the remaining words before the start.
// Reset rst is synchronous and active-low.
module dsp_sample_loader #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic [ADDR_W-1:0]         cfg_base,
    input  logic [ADDR_W-1:0]         cfg_len,
    dsp_sample_loader_if.slave        bus,
    output logic                      busy,
    output logic                      frame_err,
    output logic [ADDR_W-1:0]         loaded_cnt
);

`ifdef DSP_LOADER_PAD_EN
    typedef enum logic [2:0] {IDLE, LOAD, PAD, START, RUN} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN} state_t;
`endif

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [ADDR_W-1:0]   len_reg, len_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic                last_seen_reg, last_seen_next;
    logic                s_ready_reg, s_ready_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                frame_err_reg, frame_err_next;
    logic [ADDR_W-1:0]   loaded_cnt_reg, loaded_cnt_next;

    // s_ready is only ever high in LOAD, so a handshake implies LOAD.
    logic                hs;
    // One extra bit keeps the idx+1 compare against len exact at the top of the range.
    logic [ADDR_W:0]     idx_inc;
    logic [ADDR_W:0]     len_ext;

    assign hs      = bus.s_valid & s_ready_reg;
    assign idx_inc = {1'b0, idx_reg} + {{ADDR_W{1'b0}}, 1'b1};
    assign len_ext = {1'b0, len_reg};

    assign bus.s_ready    = s_ready_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    // START is entered only after the cycle carrying the final write, so the
    // start pulse can never coincide with or precede a frame write.
    assign bus.core_start = (state_reg == START);
    assign busy           = (state_reg != IDLE);
    assign frame_err      = frame_err_reg;
    assign loaded_cnt     = loaded_cnt_reg;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        len_next        = len_reg;
        idx_next        = idx_reg;
        last_seen_next  = last_seen_reg;
        s_ready_next    = s_ready_reg;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        frame_err_next  = frame_err_reg;
        loaded_cnt_next = loaded_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (arm) begin
                    base_next       = cfg_base;
                    len_next        = cfg_len;
                    idx_next        = '0;
                    last_seen_next  = 1'b0;
                    frame_err_next  = 1'b0;
                    loaded_cnt_next = '0;
                    if (cfg_len == '0) begin
                        state_next   = START;
                        s_ready_next = 1'b0;
                    end else begin
                        state_next   = LOAD;
                        s_ready_next = 1'b1;
                    end
                end
            end

            LOAD: begin
                // The exit test uses registered idx/last, so it fires in the cycle
                // in which the final write is on the memory port.
                if ((idx_reg == len_reg) || last_seen_reg) begin
                    s_ready_next = 1'b0;
`ifdef DSP_LOADER_PAD_EN
                    state_next   = (idx_reg == len_reg) ? START : PAD;
`else
                    state_next   = START;
`endif
                end else if (hs) begin
                    mem_we_next     = 1'b1;
                    mem_addr_next   = base_reg + idx_reg;
                    mem_wdata_next  = {{(DATA_W-SAMPLE_W){bus.s_data[SAMPLE_W-1]}}, bus.s_data};
                    idx_next        = idx_inc[ADDR_W-1:0];
                    loaded_cnt_next = loaded_cnt_reg + ADDR_W'(1);
                    if (bus.s_last) begin
                        last_seen_next = 1'b1;
                    end
                    // Mismatch: the len-th sample lacks s_last, or s_last came early.
                    if ((idx_inc == len_ext) != bus.s_last) begin
                        frame_err_next = 1'b1;
                    end
                    s_ready_next = (idx_inc < len_ext) && !bus.s_last;
                end
            end

`ifdef DSP_LOADER_PAD_EN
            PAD: begin
                if (idx_reg == len_reg) begin
                    state_next = START;
                end else begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = base_reg + idx_reg;
                    mem_wdata_next = '0;
                    idx_next       = idx_reg + ADDR_W'(1);
                end
            end
`endif

            START: begin
                state_next = RUN;
            end

            RUN: begin
                if (bus.core_done) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next   = IDLE;
                s_ready_next = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            len_reg        <= '0;
            idx_reg        <= '0;
            last_seen_reg  <= 1'b0;
            s_ready_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            frame_err_reg  <= 1'b0;
            loaded_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            len_reg        <= len_next;
            idx_reg        <= idx_next;
            last_seen_reg  <= last_seen_next;
            s_ready_reg    <= s_ready_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            frame_err_reg  <= frame_err_next;
            loaded_cnt_reg <= loaded_cnt_next;
        end
    end

endmodule

// File: tb/tb_dsp_sample_loader.sv
// Scoreboard bench for dsp_sample_loader.
// The stimulus side pushes the expected memory writes and start pulses.
// A negedge monitor pops and compares them as the DUT produces them.
// Expectations follow the frame rules directly:
//   - sample i of a frame lands at (base+i) mod 1024 as a signed 32-bit value
//   - a frame whose s_last is misplaced sets frame_err
//   - with DSP_LOADER_PAD_EN, a short frame is zero-filled before the start
module tb_dsp_sample_loader;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              arm = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W-1:0] cfg_len = '0;
    logic              busy;
    logic              frame_err;
    logic [ADDR_W-1:0] loaded_cnt;

    dsp_sample_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W)) bus ();

    dsp_sample_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .bus        (bus.slave),
        .busy       (busy),
        .frame_err  (frame_err),
        .loaded_cnt (loaded_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t         wr_q[$];
    wr_t         mon_e;
    int          starts_pending = 0;
    int          starts_seen = 0;
    int          vec = 0;
    int          miss = 0;
    logic [15:0] stim[16];
    logic        exp_err;
    int          exp_cnt;

    function automatic void check(string name, longint act, longint exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endfunction

    function automatic logic [DATA_W-1:0] sext(logic [15:0] s);
        int v;
        v = $signed(s);
        return DATA_W'(v);
    endfunction

    // Monitor: every write and every start pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", longint'(bus.mem_we), 0);
            end else begin
                mon_e = wr_q.pop_front();
                check("wr_addr", longint'(bus.mem_addr), longint'(mon_e.addr));
                check("wr_data", longint'(bus.mem_wdata), longint'(mon_e.data));
            end
        end
        if (bus.core_start === 1'b1) begin
            if (starts_pending == 0) begin
                check("unexpected_start", longint'(bus.core_start), 0);
            end else begin
                starts_pending--;
                check("start_after_writes", longint'(wr_q.size()), 0);
                check("start_no_we", longint'(bus.mem_we), 0);
            end
            starts_seen++;
        end
    end

    // Arm a frame, stream its samples, and wait for the start pulse.
    // lastpos: index carrying s_last, or -1 for none.
    // vmode: 0 = always valid, 1 = toggle, 2 = random.
    // hold: cycles to keep s_valid high once the frame is fully sent.
    task automatic send_frame(input logic [ADDR_W-1:0] base, input int len,
                              input int lastpos, input int vmode, input int hold);
        int  i;
        int  cyc;
        int  nsend;
        int  sb;
        logic v;
        wr_t e;
        nsend   = (lastpos >= 0 && lastpos < len) ? lastpos + 1 : len;
        exp_err = (len > 0) && (lastpos != len - 1);
        exp_cnt = nsend;
        cfg_base = base;
        cfg_len  = ADDR_W'(len);
        arm      = 1'b1;
        sb       = starts_seen;
        starts_pending++;
        @(negedge clk);
        arm      = 1'b0;
        cfg_base = ADDR_W'($urandom);
        cfg_len  = ADDR_W'($urandom);
        if (len == 0) begin
            check("len0_start_next_cycle", longint'(bus.core_start), 1);
        end
        i   = 0;
        cyc = 0;
        while (i < nsend && cyc < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid   = v;
            bus.s_data    = stim[i];
            bus.s_last    = (i == lastpos);
            bus.core_done = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (v && bus.s_ready === 1'b1) begin
                e.addr = ADDR_W'((int'(base) + i) % 1024);
                e.data = sext(stim[i]);
                wr_q.push_back(e);
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.core_done = 1'b0;
        check("samples_accepted", longint'(i), longint'(nsend));
`ifdef DSP_LOADER_PAD_EN
        for (int j = nsend; j < len; j++) begin
            e.addr = ADDR_W'((int'(base) + j) % 1024);
            e.data = '0;
            wr_q.push_back(e);
        end
`endif
        if (len > 0) begin
            check("ready_low_after_frame", longint'(bus.s_ready), 0);
        end
        bus.s_valid = (hold > 0);
        bus.s_data  = 16'h5a5a;
        bus.s_last  = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("ready_low_while_held", longint'(bus.s_ready), 0);
        end
        bus.s_valid = 1'b0;
        cyc = 0;
        while (starts_seen == sb && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("start_count", longint'(starts_seen - sb), 1);
        check("frame_err", longint'(frame_err), longint'(exp_err));
        check("loaded_cnt", longint'(loaded_cnt), longint'(exp_cnt));
    endtask

    // Finish RUN: optionally try a re-arm (must be ignored), then give core_done.
    task automatic finish_run(input bit arm_in_run, input int delay);
        if (arm_in_run) begin
            cfg_base = 10'd300;
            cfg_len  = 10'd3;
            arm      = 1'b1;
            bus.s_valid = 1'b1;
            @(negedge clk);
            arm = 1'b0;
            @(negedge clk);
            bus.s_valid = 1'b0;
            check("run_arm_ignored_busy", longint'(busy), 1);
            check("run_ready_low", longint'(bus.s_ready), 0);
            check("run_arm_keeps_err", longint'(frame_err), longint'(exp_err));
        end
        repeat (delay) @(negedge clk);
        check("busy_in_run", longint'(busy), 1);
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
        check("idle_after_done", longint'(busy), 0);
    endtask

    initial begin
        int sb;
        int len;
        int lp;
        wr_t e;

        // Reset held with active-looking inputs.
        rst = 1'b0;
        arm = 1'b1;
        cfg_len = 10'd4;
        bus.s_valid   = 1'b1;
        bus.s_data    = 16'hffff;
        bus.s_last    = 1'b1;
        bus.core_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_s_ready", longint'(bus.s_ready), 0);
            check("rst_mem_we", longint'(bus.mem_we), 0);
            check("rst_core_start", longint'(bus.core_start), 0);
            check("rst_busy", longint'(busy), 0);
            check("rst_frame_err", longint'(frame_err), 0);
            check("rst_mem_addr", longint'(bus.mem_addr), 0);
            check("rst_mem_wdata", longint'(bus.mem_wdata), 0);
            check("rst_loaded_cnt", longint'(loaded_cnt), 0);
        end
        rst = 1'b1;
        arm = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.core_done = 1'b0;
        @(negedge clk);

        // Nominal frame.
        stim[0] = 16'd1; stim[1] = 16'd2; stim[2] = 16'd3; stim[3] = 16'd4;
        send_frame(10'd0, 4, 3, 0, 0);
        finish_run(1'b0, 2);

        // Sign extension and address wrap.
        stim[0] = 16'hffff; stim[1] = 16'h8000;
        send_frame(10'd1022, 2, 1, 0, 0);
        finish_run(1'b0, 0);
        stim[0] = 16'h1234; stim[1] = 16'hfedc;
        send_frame(10'd1023, 2, 1, 0, 0);
        finish_run(1'b0, 1);

        // Backpressure: toggled valid, then valid held after the last sample.
        for (int k = 0; k < 4; k++) stim[k] = 16'($urandom);
        send_frame(10'd1021, 4, 3, 1, 3);
        finish_run(1'b0, 0);

        // Early last, with an ignored arm while running.
        stim[0] = 16'h0011; stim[1] = 16'd7;
        send_frame(10'd100, 4, 1, 0, 0);
        finish_run(1'b1, 1);

        // Zero-length frame.
        send_frame(10'd5, 0, -1, 0, 0);
        finish_run(1'b0, 0);

        // Reset in the middle of LOAD: pending writes land, no start follows.
        sb = starts_seen;
        cfg_base = 10'd200;
        cfg_len  = 10'd8;
        arm      = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stim[k] = 16'($urandom);
            bus.s_valid = 1'b1;
            bus.s_data  = stim[k];
            bus.s_last  = 1'b0;
            e.addr = ADDR_W'(200 + k);
            e.data = sext(stim[k]);
            wr_q.push_back(e);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_loaded_cnt", longint'(loaded_cnt), 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_start", longint'(starts_seen - sb), 0);
        check("midrst_writes_done", longint'(wr_q.size()), 0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 12);
            case ($urandom_range(0, 2))
                0:       lp = len - 1;
                1:       lp = $urandom_range(0, len - 1);
                default: lp = -1;
            endcase
            for (int k = 0; k < 16; k++) stim[k] = 16'($urandom);
            send_frame(ADDR_W'($urandom), len, lp, 2, $urandom_range(0, 2));
            finish_run(1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end

        repeat (3) @(negedge clk);
        check("final_no_pending_writes", longint'(wr_q.size()), 0);
        check("final_no_pending_starts", longint'(starts_pending), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
